// File: rtl/add_sub_pkg.sv
// Shared definitions for the serial adder/subtractor: FSM encodings, function codes
// and the slice-counter width helper.
package add_sub_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic FNC_ADD = 1'b0;
    localparam logic FNC_SUB = 1'b1;

    // A single-slice build still needs a 1-bit counter to keep the port legal.
    function automatic int cnt_width(input int n, input int k);
        int w;
        w = $clog2(n / k);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/add_sub_slice.sv
// K-bit combinational ripple-carry slice, reused every cycle by the serial engine.
// Latency: purely combinational. Backpressure: none (no state).
// Exposes carry-out and the carry into the slice MSB for overflow detection.
module add_sub_slice #(
    parameter int K = 4
) (
    input  logic [K-1:0] a,
    input  logic [K-1:0] b,
    input  logic         cin,
    output logic [K-1:0] sum,
    output logic         cout,
    output logic         cmsb
);

    logic [K:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int i = 0; i < K; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign cout = c[K];
    assign cmsb = c[K-1];

endmodule

// File: rtl/serial_add_sub_accumulator.sv
// Serial N-bit add/sub with accumulator, K bits per cycle (ADD_SUB_SATURATE_EN enables clamping).
// Latency: out_valid rises N/K cycles after acceptance; issue interval N/K+2.
// Backpressure: result held in DONE until out_ready; in_ready low outside IDLE.
module serial_add_sub_accumulator
    import add_sub_pkg::*;
#(
    parameter int N = 16,
    parameter int K = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         fnc,
    input  logic         acc,
    input  logic         clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] result,
    output logic         sovf,
    output logic         uovf
);

    localparam int NS = N / K;
    localparam int CW = cnt_width(N, K);
    localparam logic [CW-1:0] LAST = CW'(NS - 1);

    logic [1:0]    state;
    logic [N-1:0]  op_a;
    logic [N-1:0]  op_b;
    logic [N-1:0]  work;
    logic          carry;
    logic [CW-1:0] idx;
    logic [N-1:0]  result_q;
    logic          sovf_q;
    logic          uovf_q;
    logic [N-1:0]  acc_q;

    logic [31:0]   base;
    logic [K-1:0]  sl_sum;
    logic          sl_cout;
    logic          sl_cmsb;
    logic [N-1:0]  full_nxt;
    logic [N-1:0]  final_res;
    logic          raw_sovf;

    assign base = 32'(idx) * 32'(K);

    add_sub_slice #(.K(K)) u_slice (
        .a    (op_a[base +: K]),
        .b    (op_b[base +: K]),
        .cin  (carry),
        .sum  (sl_sum),
        .cout (sl_cout),
        .cmsb (sl_cmsb)
    );

    // On the last slice the slice MSB carry is c[N-1] and its carry-out is c[N].
    assign raw_sovf = sl_cout ^ sl_cmsb;

    always_comb begin
        full_nxt              = work;
        full_nxt[base +: K]   = sl_sum;
`ifdef ADD_SUB_SATURATE_EN
        if (raw_sovf)
            final_res = op_a[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        else
            final_res = full_nxt;
`else
        final_res = full_nxt;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            op_a     <= '0;
            op_b     <= '0;
            work     <= '0;
            carry    <= 1'b0;
            idx      <= '0;
            result_q <= '0;
            sovf_q   <= 1'b0;
            uovf_q   <= 1'b0;
            acc_q    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (clr)
                        acc_q <= '0;
                    if (in_valid) begin
                        op_a  <= acc ? (clr ? '0 : acc_q) : a;
                        op_b  <= (fnc == FNC_SUB) ? ~b : b;
                        carry <= (fnc == FNC_SUB);
                        idx   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    work  <= full_nxt;
                    carry <= sl_cout;
                    idx   <= idx + 1'b1;
                    if (idx == LAST) begin
                        result_q <= final_res;
                        sovf_q   <= raw_sovf;
                        uovf_q   <= sl_cout;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc_q <= result_q;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign result    = result_q;
    assign sovf      = sovf_q;
    assign uovf      = uovf_q;

endmodule

// File: tb/tb_serial_add_sub_accumulator.sv
// Self-checking bench for serial_add_sub_accumulator with N=8, K=4 against an arithmetic model.
module tb_serial_add_sub_accumulator;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       fnc;
    logic       acc;
    logic       clr;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       sovf;
    logic       uovf;

    int         total = 0;
    int         bad   = 0;
    logic [7:0] model_acc = 8'h00;

    serial_add_sub_accumulator #(.N(8), .K(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .fnc       (fnc),
        .acc       (acc),
        .clr       (clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .sovf      (sovf),
        .uovf      (uovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns {sovf, uovf, result} from plain 9-bit arithmetic.
    function automatic logic [9:0] model(input logic [7:0] opa, input logic [7:0] opb, input logic f);
        logic [7:0] bb;
        logic [8:0] s;
        logic       so;
        logic [7:0] r;
        bb = f ? ~opb : opb;
        s  = {1'b0, opa} + {1'b0, bb} + {8'h00, f};
        so = (opa[7] == bb[7]) && (s[7] != opa[7]);
        r  = s[7:0];
`ifdef ADD_SUB_SATURATE_EN
        if (so)
            r = opa[7] ? 8'h80 : 8'h7F;
`endif
        return {so, s[8], r};
    endfunction

    task automatic do_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                         input logic f, input logic ac, input logic cl, input int hold);
        logic [7:0] opa;
        logic [9:0] m;
        int         cyc;
        opa = ac ? (cl ? 8'h00 : model_acc) : ia;
        m   = model(opa, ib, f);
        a = ia; b = ib; fnc = f; acc = ac; clr = cl;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        clr      = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, cyc, 2);
        check({tag, "_result"}, {24'h0, result}, {24'h0, m[7:0]});
        check({tag, "_uovf"}, {31'h0, uovf}, {31'h0, m[8]});
        check({tag, "_sovf"}, {31'h0, sovf}, {31'h0, m[9]});
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 8'($urandom); b = 8'($urandom); fnc = 1'($urandom); acc = 1'($urandom);
            @(posedge clk); #1;
            check({tag, "_hold_result"}, {24'h0, result}, {24'h0, m[7:0]});
            check({tag, "_hold_flags"}, {30'h0, sovf, uovf}, {30'h0, m[9], m[8]});
            check({tag, "_hold_vld_rdy"}, {30'h0, out_valid, in_ready}, 32'h2);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_back_idle"}, {30'h0, out_valid, in_ready}, 32'h1);
        model_acc = m[7:0];
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; a = '0; b = '0; fnc = 1'b0;
        acc = 1'b0; clr = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_in_ready", {31'h0, in_ready}, 32'h1);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_result", {24'h0, result}, 32'h0);
        check("rst_flags", {30'h0, sovf, uovf}, 32'h0);

        do_op("add", 8'h05, 8'h03, 1'b0, 1'b0, 1'b0, 0);
        do_op("sovf", 8'h7F, 8'h01, 1'b0, 1'b0, 1'b0, 0);
        do_op("sub_pos", 8'h05, 8'h03, 1'b1, 1'b0, 1'b0, 0);
        do_op("sub_neg", 8'h03, 8'h05, 1'b1, 1'b0, 1'b0, 0);

        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        model_acc = 8'h00;
        for (int i = 0; i < 3; i++)
            do_op("accum", 8'($urandom), 8'h10, 1'b0, 1'b1, 1'b0, 0);
        check("accum_total", {24'h0, model_acc}, 32'h30);

        do_op("backpressure", 8'h00, 8'h05, 1'b0, 1'b1, 1'b0, 5);

        a = 8'h01; b = 8'h02; fnc = 1'b0; acc = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_in_ready", {31'h0, in_ready}, 32'h1);
        check("midrst_out_valid", {31'h0, out_valid}, 32'h0);
        check("midrst_result", {24'h0, result}, 32'h0);
        check("midrst_flags", {30'h0, sovf, uovf}, 32'h0);
        model_acc = 8'h00;
        do_op("midrst_acc", 8'hAA, 8'h00, 1'b0, 1'b1, 1'b0, 0);

        for (int i = 0; i < 40; i++)
            do_op("rand", 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 7) == 0), int'($urandom_range(0, 2)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial_add_sub_accumulator.md
# serial_add_sub_accumulator

Multi-cycle N-bit adder/subtractor that processes operands K bits per clock, with signed and unsigned overflow flags, an internal accumulator, and valid/ready handshakes on both input and output. It is the sequential successor to our combinational generic adder/subtractor. It sits in datapaths where area matters more than latency, such as running sums and counters fed from a controller FSM.

## Interface
Parameters:
- `N`, default 16: operand width in bits; must be a multiple of `K`.
- `K`, default 4: slice width processed per cycle; `N/K` ≥ 1.

Ports:
- `clk`, input, 1: the only clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-high.
- `in_valid`, input, 1: operands and controls are valid.
- `in_ready`, output, 1: block can accept an operation.
- `a`, input, N: operand A (ignored when `acc`=1).
- `b`, input, N: operand B.
- `fnc`, input, 1: 0 = A+B, 1 = A−B.
- `acc`, input, 1: 1 = use the accumulator register as operand A.
- `clr`, input, 1: zero the accumulator (honoured in IDLE only).
- `out_valid`, output, 1: result and flags are valid.
- `out_ready`, input, 1: consumer takes the result.
- `result`, output, N: sum or difference.
- `sovf`, output, 1: signed overflow, c[N] ^ c[N−1].
- `uovf`, output, 1: carry out c[N]. For subtract, 1 means no borrow.

## Operation
- FSM states: IDLE, RUN, DONE. `in_ready` = (state==IDLE). `out_valid` = (state==DONE).
- IDLE:
  - On `in_valid` && `in_ready`: latch opA = `acc` ? accReg : `a`; opB = `b` ^ {N{`fnc`}}; carry = `fnc`; slice = 0; go to RUN.
  - `clr` in IDLE zeroes accReg. If `clr` and accept happen in the same cycle, opA uses 0 when `acc`=1.
- RUN:
  - Each cycle, add slice `[slice*K +: K]` of opA, opB and carry. Write the K-bit sum into the result register and update carry.
  - On the last slice, also capture the carry into the MSB (c[N−1]).
  - After slice N/K−1, go to DONE.
- DONE:
  - `result`, `sovf` and `uovf` are held stable.
  - On `out_ready`: accReg ← `result` (post-saturation), go to IDLE.
- While not in IDLE, `in_valid` is ignored and no inputs are sampled. `clr` outside IDLE is ignored.
- Arithmetic is modulo 2^N two's complement. Flags are computed exactly as in a full N-bit ripple add of A + (B^fnc) + fnc.

## Timing
- Reset values: state IDLE, `in_ready`=1, `out_valid`=0, `result`=0, `sovf`=0, `uovf`=0, accReg=0.
- Latency: acceptance at edge E0. `out_valid` rises after edge E(N/K), i.e. N/K cycles later.
- Minimum issue interval: N/K+2 cycles (RUN, DONE with `out_ready`=1, IDLE accept).
- Outputs change only on state transitions. They are stable for the whole DONE state regardless of `out_ready`.
- Reset asserted in any state aborts the operation: no `out_valid` pulse, accReg cleared, outputs at reset values on the next cycle.
- N/K=1: a single RUN cycle; behaviour is otherwise identical.

## Configuration
- `ADD_SUB_SATURATE_EN` defined: when `sovf`=1, `result` and accReg clamp to signed max (0111…1) if opA MSB=0, or signed min (1000…0) if opA MSB=1. `sovf` and `uovf` still report the raw overflow.
- Not defined: `result` wraps modulo 2^N; no clamp logic is synthesised.

## Structure
- Shared package `add_sub_pkg` holds:
  - state encodings IDLE/RUN/DONE;
  - `FNC_ADD`=0, `FNC_SUB`=1;
  - a function for the slice-counter width, clog2(N/K).
- Sub-module `add_sub_slice`: a K-bit combinational ripple of full adders with carry-in and carry-out, plus an exposed carry into its MSB. It is instantiated once and reused across cycles.

## Test plan
Benches use N=8, K=4.
- Add: `a`=0x05, `b`=0x03, `fnc`=0, `acc`=0 -> `result`=0x08, `sovf`=0, `uovf`=0; `out_valid` 2 cycles after accept.
- Signed overflow: `a`=0x7F, `b`=0x01, add -> `result`=0x80, `sovf`=1, `uovf`=0. With `ADD_SUB_SATURATE_EN`: `result`=0x7F, `sovf`=1.
- Subtract:
  - `a`=0x05, `b`=0x03 -> `result`=0x02, `uovf`=1.
  - `a`=0x03, `b`=0x05 -> `result`=0xFE, `uovf`=0, `sovf`=0.
- Accumulate: `clr` in IDLE, then three ops with `acc`=1, `b`=0x10, add -> `result` 0x10, 0x20, 0x30.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE -> `result` and flags stable, `in_ready`=0, a concurrent `in_valid` is not accepted.
- Reset mid-RUN: assert `reset` one cycle after accept -> next cycle `in_ready`=1, `out_valid`=0, `result`=0, accReg=0.
